// File: rtl/uart_rx_fsm_if.sv
// Control bundle between the UART RX frame FSM and its sampler/checker/deserializer datapath.
// err_pulse exists only when RX_ERR_FLAGS_EN is defined.
interface uart_rx_fsm_if;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic       data_valid;
    logic       par_err;
    logic       strt_glitch;
    logic       stp_err;
`ifdef RX_ERR_FLAGS_EN
    logic [1:0] err_pulse;

    modport master (
        output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
               deser_en, data_valid, err_pulse,
        input  par_err, strt_glitch, stp_err
    );
    modport slave (
        input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
               deser_en, data_valid, err_pulse,
        output par_err, strt_glitch, stp_err
    );
`else
    modport master (
        output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
               deser_en, data_valid,
        input  par_err, strt_glitch, stp_err
    );
    modport slave (
        input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en,
               deser_en, data_valid,
        output par_err, strt_glitch, stp_err
    );
`endif
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver frame controller: start detect, edge/bit counters, datapath enables, data_valid.
// Define RX_ERR_FLAGS_EN to add the registered {stop, parity} err_pulse output.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RX_IN,
    input  logic [5:0]    PRESCALE,
    input  logic          PAR_EN,
    uart_rx_fsm_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CHECK} state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

    state_t     state;
    logic [5:0] presc_q;
    logic       par_en_q;
    logic       bit_end;
    logic       data_first;

    // Frame configuration is frozen while a frame is in flight.
    assign bit_end    = (bus.edge_cnt == 6'(presc_q - 6'd1));
    assign data_first = (state == DATA) && (bus.bit_cnt == 4'd1) && (bus.edge_cnt == 6'd0);

    assign bus.dat_samp_en = (state == START) || (state == DATA) ||
                             (state == PARITY) || (state == STOP);
    assign bus.strt_chk_en = (state == START);
    assign bus.deser_en    = (state == DATA);
    assign bus.par_chk_en  = (state == PARITY);
    assign bus.stp_chk_en  = (state == STOP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            bus.edge_cnt   <= '0;
            bus.bit_cnt    <= '0;
            presc_q        <= 6'd8;
            par_en_q       <= 1'b0;
            bus.data_valid <= 1'b0;
`ifdef RX_ERR_FLAGS_EN
            bus.err_pulse  <= 2'b00;
`endif
        end else begin
            bus.data_valid <= 1'b0;
`ifdef RX_ERR_FLAGS_EN
            bus.err_pulse  <= 2'b00;
`endif
            case (state)
                IDLE: begin
                    presc_q      <= PRESCALE;
                    par_en_q     <= PAR_EN;
                    bus.edge_cnt <= '0;
                    bus.bit_cnt  <= '0;
                    if (!RX_IN) state <= START;
                end
                CHECK: begin
                    bus.data_valid <= !bus.stp_err && !(par_en_q && bus.par_err);
`ifdef RX_ERR_FLAGS_EN
                    bus.err_pulse  <= {bus.stp_err, bus.par_err & par_en_q};
`endif
                    bus.edge_cnt   <= '0;
                    bus.bit_cnt    <= '0;
                    state          <= RX_IN ? IDLE : START;
                end
                default: begin
                    // A false start is only known once the start checker has latched.
                    if (data_first && bus.strt_glitch) begin
                        state        <= IDLE;
                        bus.edge_cnt <= '0;
                        bus.bit_cnt  <= '0;
                    end else begin
                        bus.edge_cnt <= bit_end ? 6'd0 : 6'(bus.edge_cnt + 6'd1);
                        if (bit_end) begin
                            bus.bit_cnt <= 4'(bus.bit_cnt + 4'd1);
                            case (state)
                                START:   state <= DATA;
                                DATA:    if (bus.bit_cnt == LAST_DATA)
                                             state <= par_en_q ? PARITY : STOP;
                                PARITY:  state <= STOP;
                                STOP:    state <= CHECK;
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule
